sbox_layer: RTL and testbench
=============================

# sbox_layer

Iterative 4-bit S-box substitution layer for the FUTURE datapath. It takes a DATA_W-bit state and substitutes every nibble through the cipher S-box, processing LANES nibbles per clock. Transfers in and out use valid/ready handshakes. It sits between the round-key addition and the MixColumns/ShiftRows stages of the round datapath, and it generalises the single combinational S-box to a full-state, area-scalable, optionally invertible layer.

## Interface
- DATA_W, default 64: state width in bits. Must be a multiple of 4.
- LANES, default 4: S-box instances evaluated per cycle. (DATA_W/4) % LANES == 0 is required; otherwise elaboration fails with $error.
- NBEATS (localparam) = DATA_W/(4*LANES): substitution cycles per block.
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_data/in_inv are valid.
- in_ready, output, 1: block can accept an input.
- in_data, input, DATA_W: state to substitute. Nibble i is bits [4i+3:4i], with bit 4i as the LSB (x0).
- in_inv, input, 1: 1 selects the inverse S-box (see Configuration).
- out_valid, output, 1: out_data holds a completed result.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, DATA_W: substituted state.
- busy, output, 1: high in RUN and DONE.

## Operation
- Forward S-box, input 0..F: 1,3,0,2,7,E,4,D,9,A,C,6,F,5,8,B.
- Inverse S-box, input 0..F: 2,0,3,1,6,D,B,4,E,8,9,F,A,7,5,C.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, capture in_data into the state register, latch in_inv into the mode flag, set beat counter to 0, and go to RUN.
  - RUN: each cycle, replace the lowest LANES nibbles with S(nibble) or S⁻¹(nibble). Rotate the register right by 4*LANES bits. Increment the counter. On the cycle where counter == NBEATS-1, go to DONE.
  - DONE: out_valid=1 and out_data = state register. On out_ready, go to IDLE.
- After NBEATS rotations the nibble alignment is restored, so out nibble i = S(in nibble i).
- in_ready = (state==IDLE). Inputs offered in RUN or DONE are not taken; the producer holds them.
- out_data and the mode flag are stable while out_valid is high and out_ready is low.
- The beat counter is $clog2(NBEATS+1) bits wide. It never wraps within a block.

## Timing
- Reset values:
  - state IDLE, register 0, counter 0, mode 0.
  - in_ready 1, out_valid 0, out_data 0, busy 0.
- Input handshake at edge t: RUN covers edges t+1..t+NBEATS. out_valid rises after edge t+NBEATS. Default parameters give 4 cycles.
- Output handshake at edge u (out_valid and out_ready both high): out_valid drops and in_ready rises after edge u. The earliest next accept is edge u+1.
- Throughput is one block per NBEATS+2 cycles with no stalls.
- out_ready high at the moment DONE is entered: the output transfer completes on the first DONE edge, so out_valid is high for exactly one cycle.
- rst_n asserted mid-RUN or mid-DONE: the block is dropped immediately (asynchronous). All outputs take their reset values. No partial result is emitted.
- LANES = DATA_W/4: NBEATS=1, and a single RUN cycle substitutes the whole state.

## Configuration
- SBOX_LAYER_INV_EN defined:
  - The inverse table is compiled in.
  - in_inv, latched at accept, selects the table per block.
- SBOX_LAYER_INV_EN undefined:
  - The inverse table is not built.
  - in_inv is ignored and the mode flag is tied to 0, so every block uses the forward S-box.
  - The port list is unchanged.

## Structure
- Shared package future_pkg holds:
  - SBOX_FWD and SBOX_INV as 16-entry 4-bit constant arrays.
  - The FSM state typedef (IDLE/RUN/DONE).
  - The nibble typedef.
- Sub-module sbox_lane: a combinational 4-bit lookup with an inv select. It is instantiated LANES times via generate.

## Test plan
- Forward sweep (DATA_W=64, LANES=4):
  - in_data=0xFEDCBA9876543210, in_inv=0, out_ready=1 → out_data=0xB85F6CA9D4E72031.
  - out_valid rises 4 cycles after accept.
- Inverse round trip (macro defined): in_data=0xB85F6CA9D4E72031, in_inv=1 → out_data=0xFEDCBA9876543210.
- Backpressure:
  - in_data=0 with out_ready held low for 5 cycles → out_data=0x1111111111111111 stable, out_valid high, in_ready 0 throughout.
  - A second in_valid during this window is not accepted.
- Reset mid-run: assert rst_n=0 on the second RUN cycle → out_valid=0, out_data=0, in_ready=1 immediately. A following block of 0 yields 0x1111111111111111.
- LANES=16, NBEATS=1: in_data=0xFEDCBA9876543210 → 0xB85F6CA9D4E72031 with out_valid after 1 cycle. Back-to-back blocks are accepted every 3 cycles.
- Macro undefined: in_inv=1, in_data=0 → out_data=0x1111111111111111 (forward S-box used).

Source files
------------

// File: rtl/future_pkg.sv
// Shared types and S-box tables for the FUTURE round datapath.
// Used by sbox_layer and sbox_lane.
package future_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_RUN  = 2'd1;
  localparam fsm_state_t ST_DONE = 2'd2;

  localparam nibble_t SBOX_FWD [16] = '{
    4'h1, 4'h3, 4'h0, 4'h2, 4'h7, 4'hE, 4'h4, 4'hD,
    4'h9, 4'hA, 4'hC, 4'h6, 4'hF, 4'h5, 4'h8, 4'hB
  };

  localparam nibble_t SBOX_INV [16] = '{
    4'h2, 4'h0, 4'h3, 4'h1, 4'h6, 4'hD, 4'hB, 4'h4,
    4'hE, 4'h8, 4'h9, 4'hF, 4'hA, 4'h7, 4'h5, 4'hC
  };

endpackage

// File: rtl/sbox_lane.sv
// Combinational 4-bit S-box lookup with forward/inverse select.
// The inverse table is only built when SBOX_LAYER_INV_EN is defined.
module sbox_lane
  import future_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       inv,
  output logic [3:0] sub
);

`ifdef SBOX_LAYER_INV_EN
  assign sub = inv ? SBOX_INV[nib] : SBOX_FWD[nib];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign sub = SBOX_FWD[nib];
`endif

endmodule

// File: rtl/sbox_layer.sv
// Iterative S-box layer: LANES nibbles substituted per cycle over NBEATS cycles.
// Optional inverse mode via SBOX_LAYER_INV_EN.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for an input block, in_ready high
//   RUN     | substituting LANES nibbles per cycle and rotating
//   DONE    | result held on out_data until out_ready
module sbox_layer
  import future_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int NBEATS = DATA_W / (4 * LANES);
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam int LW     = 4 * LANES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  generate
    if ((DATA_W % 4) != 0 || ((DATA_W / 4) % LANES) != 0) begin : g_bad_cfg
      $error("sbox_layer: DATA_W must be a multiple of 4 and DATA_W/4 a multiple of LANES");
    end
  endgenerate

  fsm_state_t        state_q;
  logic [DATA_W-1:0] reg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mode_q;
  logic              mode_in;
  logic [LW-1:0]     sub_vec;
  logic [DATA_W-1:0] rot_next;

`ifdef SBOX_LAYER_INV_EN
  assign mode_in = in_inv;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign mode_in       = 1'b0;
`endif

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      sbox_lane u_lane (
        .nib (reg_q[4*g +: 4]),
        .inv (mode_q),
        .sub (sub_vec[4*g +: 4])
      );
    end

    // Substituted low slice moves to the top; after NBEATS beats alignment is restored.
    if (NBEATS == 1) begin : g_rot_single
      assign rot_next = sub_vec;
    end else begin : g_rot_multi
      assign rot_next = {sub_vec, reg_q[DATA_W-1:LW]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      reg_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            reg_q   <= in_data;
            mode_q  <= mode_in;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          reg_q <= rot_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_data  = out_valid ? reg_q : '0;

endmodule

// File: tb/tb_sbox_layer.sv
// Self-checking bench for sbox_layer: LANES=4 (NBEATS=4) and LANES=16 (NBEATS=1) instances
// against a behavioural model; inverse checks depend on SBOX_LAYER_INV_EN.
module tb_sbox_layer;

`ifdef SBOX_LAYER_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid [2];
  logic        in_inv   [2];
  logic        out_ready[2];
  logic [63:0] in_data  [2];
  logic        in_ready [2];
  logic        out_valid[2];
  logic        busy     [2];
  logic [63:0] out_data [2];

  sbox_layer #(.DATA_W(64), .LANES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_inv(in_inv[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );

  sbox_layer #(.DATA_W(64), .LANES(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_inv(in_inv[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input int k, input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %h, want %h (t=%0t)", k, nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [3:0] fwd_t [16] = '{4'h1, 4'h3, 4'h0, 4'h2, 4'h7, 4'hE, 4'h4, 4'hD,
                             4'h9, 4'hA, 4'hC, 4'h6, 4'hF, 4'h5, 4'h8, 4'hB};

  function automatic logic [3:0] inv_of(input logic [3:0] n);
    logic [3:0] r = 4'h0;
    for (int j = 0; j < 16; j++) if (fwd_t[j] == n) r = 4'(j);
    return r;
  endfunction

  function automatic logic [63:0] model_sub(input logic [63:0] x, input logic inv);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = inv ? inv_of(x[4*i +: 4]) : fwd_t[x[4*i +: 4]];
    return r;
  endfunction

  function automatic int nb(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  bit          m_busy [2] = '{0, 0};
  bit          m_valid[2] = '{0, 0};
  int          m_left [2] = '{0, 0};
  logic [63:0] m_data [2] = '{64'h0, 64'h0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_valid[k] = 0; m_left[k] = 0; m_data[k] = '0;
      end else if (m_valid[k]) begin
        if (out_ready[k]) m_valid[k] = 0;
      end else if (m_busy[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) begin m_busy[k] = 0; m_valid[k] = 1; end
      end else if (in_valid[k]) begin
        m_busy[k] = 1;
        m_left[k] = nb(k);
        m_data[k] = model_sub(in_data[k], in_inv[k] && INV_EN);
      end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check(k, "in_ready",  64'(in_ready[k]),  64'(!(m_busy[k] || m_valid[k])));
        check(k, "out_valid", 64'(out_valid[k]), 64'(m_valid[k]));
        check(k, "busy",      64'(busy[k]),      64'(m_busy[k] || m_valid[k]));
        if (m_valid[k]) check(k, "out_data", out_data[k], m_data[k]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_block(input int k, input logic [63:0] d, input logic inv,
                           output logic [63:0] res, output int lat);
    @(negedge clk);
    in_valid[k] = 1'b1; in_data[k] = d; in_inv[k] = inv; out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res = out_data[k];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int lat;
    int acc[$];
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 0; in_inv[k] = 0; out_ready[k] = 0; in_data[k] = '0;
    end

    // model pinned to hand-computed values
    check(-1, "model_fwd",  model_sub(64'hFEDCBA9876543210, 1'b0), 64'hB85F6CA9D4E72031);
    check(-1, "model_zero", model_sub(64'h0, 1'b0),                 64'h1111111111111111);
    check(-1, "model_inv",  model_sub(64'hB85F6CA9D4E72031, 1'b1), 64'hFEDCBA9876543210);

    repeat (3) @(negedge clk);
    chk_en = 1;
    for (int k = 0; k < 2; k++) begin
      check(k, "rst_in_ready",  64'(in_ready[k]),  64'd1);
      check(k, "rst_out_valid", 64'(out_valid[k]), 64'd0);
      check(k, "rst_out_data",  out_data[k],       64'd0);
      check(k, "rst_busy",      64'(busy[k]),      64'd0);
    end
    rst_n = 1'b1;

    // forward sweep and latency on both configurations
    for (int k = 0; k < 2; k++) begin
      run_block(k, 64'hFEDCBA9876543210, 1'b0, res, lat);
      check(k, "fwd_data", res, 64'hB85F6CA9D4E72031);
      check(k, "fwd_lat", 64'(lat), 64'(nb(k)));
    end

`ifdef SBOX_LAYER_INV_EN
    run_block(0, 64'hB85F6CA9D4E72031, 1'b1, res, lat);
    check(0, "inv_roundtrip", res, 64'hFEDCBA9876543210);
`else
    run_block(0, 64'h0, 1'b1, res, lat);
    check(0, "inv_ignored", res, 64'h1111111111111111);
`endif

    // backpressure: hold output 5 cycles while a second input is offered
    @(negedge clk);
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 64'h0; in_inv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin @(negedge clk); lat++; end
    for (int c = 0; c < 5; c++) begin
      check(0, "bp_data",     out_data[0],        64'h1111111111111111);
      check(0, "bp_valid",    64'(out_valid[0]),  64'd1);
      check(0, "bp_in_ready", 64'(in_ready[0]),   64'd0);
      in_valid[0] = 1'b1; in_data[0] = {$urandom, $urandom};
      @(negedge clk);
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk);
    check(0, "bp_release_valid", 64'(out_valid[0]), 64'd0);
    check(0, "bp_release_ready", 64'(in_ready[0]),  64'd1);

    // reset during RUN
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(0, "midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check(0, "midrst_out_data",  out_data[0],       64'd0);
    check(0, "midrst_in_ready",  64'(in_ready[0]),  64'd1);
    check(0, "midrst_busy",      64'(busy[0]),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, 64'h0, 1'b0, res, lat);
    check(0, "post_rst_data", res, 64'h1111111111111111);

    // back-to-back on the single-beat instance
    @(negedge clk);
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; in_data[1] = 64'hFEDCBA9876543210; in_inv[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (in_ready[1]) acc.push_back(c);
      if (out_valid[1]) check(1, "b2b_data", out_data[1], 64'hB85F6CA9D4E72031);
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    check(1, "b2b_accepts", 64'(acc.size()), 64'd4);
    for (int i = 1; i < acc.size(); i++) check(1, "b2b_gap", 64'(acc[i] - acc[i-1]), 64'd3);

    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 2) != 0);
        in_data[k]   = {$urandom, $urandom};
        in_inv[k]    = 1'($urandom_range(0, 1));
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin in_valid[k] = 0; out_ready[k] = 1; end
    repeat (8) @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
